// File: rtl/ws_array_feeder_pkg.sv
// ---------------------------------------------------------------------------
// ws_pkg : shared types and helpers for the weight-stationary array feeder.
//   state_t     : sequencer FSM states (IDLE / LOAD / STREAM / DRAIN)
//   cnt_width() : width of a counter able to hold 0..ARRAY_SIZE,
//                 i.e. $clog2(ARRAY_SIZE+1)
//   PERF_W      : width of the optional performance counters
//                 (WS_FEEDER_PERF_CNT_EN)
// ---------------------------------------------------------------------------
package ws_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOAD   = 2'd1,
        STREAM = 2'd2,
        DRAIN  = 2'd3
    } state_t;

    localparam int unsigned PERF_W = 32;
    typedef logic [PERF_W-1:0] perf_cnt_t;

    function automatic int unsigned cnt_width(input int unsigned n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/ws_array_feeder_if.sv
// ---------------------------------------------------------------------------
// ws_array_feeder_if : upstream valid/ready bus into the array feeder.
//   s_w_valid/s_w_ready/s_w_data : weight rows, slice c -> PE column c
//   s_f_valid/s_f_ready/s_f_data : fmap vectors, slice r -> PE row r
//   s_f_last                     : final fmap vector of the tile
//   modport master : upstream producer
//   modport slave  : ws_array_feeder
// ---------------------------------------------------------------------------
interface ws_array_feeder_if #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned ARRAY_SIZE = 4
);
    logic                             s_w_valid;
    logic                             s_w_ready;
    logic [ARRAY_SIZE*DATA_WIDTH-1:0] s_w_data;
    logic                             s_f_valid;
    logic                             s_f_ready;
    logic [ARRAY_SIZE*DATA_WIDTH-1:0] s_f_data;
    logic                             s_f_last;

    modport master (
        output s_w_valid, s_w_data, s_f_valid, s_f_data, s_f_last,
        input  s_w_ready, s_f_ready
    );

    modport slave (
        input  s_w_valid, s_w_data, s_f_valid, s_f_data, s_f_last,
        output s_w_ready, s_f_ready
    );
endinterface

// File: rtl/ws_array_feeder_skew_line.sv
// ---------------------------------------------------------------------------
// skew_line : DEPTH-stage delay chain for one PE row (data + valid).
//   clk, rstn : clock, synchronous active-low reset
//   i_data    : row data in          i_vld : row valid in
//   o_data    : data delayed DEPTH   o_vld : valid delayed DEPTH
// DEPTH = 0 is a straight pass-through.
// ---------------------------------------------------------------------------
module skew_line #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned DEPTH      = 0
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic [DATA_WIDTH-1:0] i_data,
    input  logic                  i_vld,
    output logic [DATA_WIDTH-1:0] o_data,
    output logic                  o_vld
);
    generate
        if (DEPTH == 0) begin : g_pass
            logic w_unused_clk_rst;
            assign w_unused_clk_rst = clk & rstn;
            assign o_data = i_data;
            assign o_vld  = i_vld;
        end else begin : g_chain
            logic [DATA_WIDTH-1:0] r_data [DEPTH];
            logic [DEPTH-1:0]      r_vld;

            always_ff @(posedge clk) begin
                if (!rstn) begin
                    for (int unsigned i = 0; i < DEPTH; i++) r_data[i] <= '0;
                    r_vld <= '0;
                end else begin
                    r_data[0] <= i_data;
                    r_vld[0]  <= i_vld;
                    for (int unsigned i = 1; i < DEPTH; i++) begin
                        r_data[i] <= r_data[i-1];
                        r_vld[i]  <= r_vld[i-1];
                    end
                end
            end

            assign o_data = r_data[DEPTH-1];
            assign o_vld  = r_vld[DEPTH-1];
        end
    endgenerate
endmodule

// File: rtl/ws_array_feeder.sv
// ---------------------------------------------------------------------------
// ws_array_feeder : front-end sequencer for an ARRAY_SIZE x ARRAY_SIZE
// weight-stationary systolic array. Preloads a weight tile, then streams
// fmap vectors into the left edge with a triangular skew (row r delayed r),
// drains the skew and pulses o_done.
//   clk, rstn   : clock, synchronous active-low reset
//   bus (slave) : weight / fmap valid-ready streams (ws_array_feeder_if)
//   o_load      : broadcast weight-load enable
//   o_weight    : top-of-column weights
//   o_fmap      : left-of-row fmap, skewed
//   o_fmap_vld  : per-row valid, skewed like o_fmap
//   o_busy      : FSM not in IDLE
//   o_done      : one-cycle pulse at end of drain
// Optional (macro WS_FEEDER_PERF_CNT_EN):
//   o_stall_cnt   : STREAM cycles with no fmap offered
//   o_tile_cycles : cycles from leaving IDLE up to and including o_done
// ---------------------------------------------------------------------------
module ws_array_feeder
    import ws_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned ARRAY_SIZE = 4
) (
    input  logic                             clk,
    input  logic                             rstn,
    ws_array_feeder_if.slave                 bus,
    output logic                             o_load,
    output logic [ARRAY_SIZE*DATA_WIDTH-1:0] o_weight,
    output logic [ARRAY_SIZE*DATA_WIDTH-1:0] o_fmap,
    output logic [ARRAY_SIZE-1:0]            o_fmap_vld,
    output logic                             o_busy,
    output logic                             o_done
`ifdef WS_FEEDER_PERF_CNT_EN
    ,
    output perf_cnt_t                        o_stall_cnt,
    output perf_cnt_t                        o_tile_cycles
`endif
);
    localparam int unsigned      CW          = cnt_width(ARRAY_SIZE);
    localparam logic [CW-1:0]    C_ROWS      = CW'(ARRAY_SIZE);
    localparam logic [CW-1:0]    C_DRAIN_END = CW'(ARRAY_SIZE - 1);

    state_t                           r_state, w_next;
    logic [CW-1:0]                    r_cnt, w_cnt_nxt;
    logic                             r_w_ready, r_f_ready;
    logic                             w_w_hs, w_f_hs;
    logic                             r_load;
    logic [ARRAY_SIZE*DATA_WIDTH-1:0] r_weight;
    logic [ARRAY_SIZE*DATA_WIDTH-1:0] r_in_data;
    logic                             r_in_vld;

    assign w_w_hs        = bus.s_w_valid & r_w_ready;
    assign w_f_hs        = bus.s_f_valid & r_f_ready;
    assign bus.s_w_ready = r_w_ready;
    assign bus.s_f_ready = r_f_ready;

    // r_cnt counts accepted weight rows in IDLE/LOAD and drain cycles in DRAIN.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_state   <= IDLE;
            r_cnt     <= '0;
            r_w_ready <= 1'b0;
            r_f_ready <= 1'b0;
        end else begin
            r_state   <= w_next;
            r_cnt     <= w_cnt_nxt;
            // Readies are registered from the next state so they are a pure
            // state decode and read 0 in the cycle following reset.
            r_w_ready <= (w_next == IDLE) || (w_next == LOAD);
            r_f_ready <= (w_next == STREAM);
        end
    end

    always_comb begin
        w_next    = r_state;
        w_cnt_nxt = r_cnt;
        o_busy    = 1'b0;
        o_done    = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (w_w_hs) begin
                    w_cnt_nxt = CW'(1);
                    w_next    = (ARRAY_SIZE == 1) ? STREAM : LOAD;
                end
            end
            LOAD: begin
                o_busy = 1'b1;
                if (w_w_hs) begin
                    w_cnt_nxt = r_cnt + 1'b1;
                    if (w_cnt_nxt == C_ROWS) w_next = STREAM;
                end
            end
            STREAM: begin
                o_busy = 1'b1;
                if (w_f_hs && bus.s_f_last) begin
                    w_next    = DRAIN;
                    w_cnt_nxt = '0;
                end
            end
            DRAIN: begin
                o_busy = 1'b1;
                // Last DRAIN cycle: final vector is leaving row N-1 now.
                if (r_cnt == C_DRAIN_END) begin
                    o_done = 1'b1;
                    w_next = IDLE;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_load    <= 1'b0;
            r_weight  <= '0;
            r_in_data <= '0;
            r_in_vld  <= 1'b0;
        end else begin
            r_load <= w_w_hs;
            if (w_w_hs) r_weight <= bus.s_w_data;
            // Idle STREAM cycles (and DRAIN) inject a zero bubble.
            r_in_data <= w_f_hs ? bus.s_f_data : '0;
            r_in_vld  <= w_f_hs;
        end
    end

    assign o_load   = r_load;
    assign o_weight = r_weight;

    for (genvar r = 0; r < ARRAY_SIZE; r++) begin : g_row
        skew_line #(
            .DATA_WIDTH (DATA_WIDTH),
            .DEPTH      (r)
        ) u_skew (
            .clk    (clk),
            .rstn   (rstn),
            .i_data (r_in_data[r*DATA_WIDTH +: DATA_WIDTH]),
            .i_vld  (r_in_vld),
            .o_data (o_fmap[r*DATA_WIDTH +: DATA_WIDTH]),
            .o_vld  (o_fmap_vld[r])
        );
    end

`ifdef WS_FEEDER_PERF_CNT_EN
    perf_cnt_t r_stall_cnt, r_tile_cycles;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_stall_cnt   <= '0;
            r_tile_cycles <= '0;
        end else if (r_state == IDLE && w_next != IDLE) begin
            r_stall_cnt   <= '0;
            r_tile_cycles <= '0;
        end else begin
            if (r_state == STREAM && !bus.s_f_valid && r_stall_cnt != '1)
                r_stall_cnt <= r_stall_cnt + 1'b1;
            if (r_state != IDLE && r_tile_cycles != '1)
                r_tile_cycles <= r_tile_cycles + 1'b1;
        end
    end

    assign o_stall_cnt   = r_stall_cnt;
    assign o_tile_cycles = r_tile_cycles;
`endif
endmodule
